// File: rtl/hack_pkg.sv
// Shared types and constants for the Hack instruction-side ROM loader.
package hack_pkg;

  localparam int INSTR_W        = 16;
  localparam int BYTE_W         = 8;
  localparam int DEFAULT_ADDR_W = 15;
  localparam int ROM_DEPTH      = 2 ** DEFAULT_ADDR_W;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    CSUM,
    RUN,
    ERROR
  } loader_state_e;

  // States in which the loader is consuming the byte stream.
  function automatic logic is_rx_state(loader_state_e s);
    return s inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM};
  endfunction

endpackage

// File: rtl/rom_loader_if.sv
// Loader-facing bundle: host byte stream, CPU fetch port and status outputs.
interface rom_loader_if
  import hack_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
);

    logic                load_req;
    logic [BYTE_W-1:0]   rx_data;
    logic                rx_valid;
    logic                rx_ready;
    logic [INSTR_W-1:0]  pcaddr;
    logic [INSTR_W-1:0]  instruction;
    logic                cpu_reset;
    logic                busy;
    logic                image_valid;
    logic                error;
    logic [ADDR_W:0]     words_loaded;

    modport master (
        output load_req, rx_data, rx_valid, pcaddr,
        input  rx_ready, instruction, cpu_reset, busy, image_valid, error, words_loaded
    );

    modport slave (
        input  load_req, rx_data, rx_valid, pcaddr,
        output rx_ready, instruction, cpu_reset, busy, image_valid, error, words_loaded
    );

endinterface

// File: rtl/rom_mem.sv
// Instruction ROM storage: one synchronous write port, one asynchronous read port.
module rom_mem
  import hack_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] mem [2 ** ADDR_W];

    // NOTE: storage arrays carry no reset; clearing them would force flops instead of RAM.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Combinational read sees the pre-edge contents, so a same-cycle write returns old data.
    assign rdata = mem[raddr];

endmodule

// File: rtl/rom_loader.sv
// Loads the Hack instruction ROM from a length-prefixed, checksummed byte stream
// and holds the CPU in reset until a verified image is present.
module rom_loader
  import hack_pkg::*;
#(
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int TIMEOUT = 1000000
) (
    input  logic         clk,
    input  logic         reset,
    rom_loader_if.slave  bus
);

    localparam int unsigned DEPTH   = 2 ** ADDR_W;
    localparam logic [31:0] TO_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

    loader_state_e      state, state_n;
    logic [BYTE_W-1:0]  sum, len_hi, data_hi;
    logic [15:0]        length, len_rx;
    logic [31:0]        idle_cnt;
    logic [ADDR_W:0]    words_loaded;
    logic               rx_ready, busy, cpu_reset, image_valid, error;
    logic               rx_state, transfer, timeout_hit, start;
    logic               rom_we;
    logic [INSTR_W-1:0] rom_rdata;

    assign rx_state    = is_rx_state(state);
    assign transfer    = bus.rx_valid && rx_ready;
    assign timeout_hit = (TIMEOUT != 0) && rx_state && !transfer && (idle_cnt == TO_LAST);
    assign len_rx      = {len_hi, bus.rx_data};
    assign start       = bus.load_req && (state inside {IDLE, RUN, ERROR});

    // NOTE: next-state defaults to the current state first so no path infers a latch.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE, RUN, ERROR: if (start) state_n = LEN_HI;
            LEN_HI:           if (transfer) state_n = LEN_LO;
            LEN_LO: if (transfer) begin
                if (32'(len_rx) > DEPTH) state_n = ERROR;
                else if (len_rx == 16'd0) state_n = CSUM;
                else                      state_n = DATA_HI;
            end
            DATA_HI:          if (transfer) state_n = DATA_LO;
            DATA_LO: if (transfer) begin
                state_n = (32'(words_loaded) + 32'd1 == 32'(length)) ? CSUM : DATA_HI;
            end
            CSUM:    if (transfer) state_n = (bus.rx_data == sum) ? RUN : ERROR;
            default:          state_n = IDLE;
        endcase
        if (timeout_hit) state_n = ERROR;
    end

    // NOTE: all state here is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            rx_ready     <= 1'b0;
            busy         <= 1'b0;
            cpu_reset    <= 1'b1;
            image_valid  <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            sum          <= '0;
            len_hi       <= '0;
            data_hi      <= '0;
            length       <= '0;
            idle_cnt     <= '0;
        end else begin
            state     <= state_n;
            rx_ready  <= is_rx_state(state_n);
            busy      <= is_rx_state(state_n);
            cpu_reset <= (state_n != RUN);
            if (start) begin
                image_valid  <= 1'b0;
                error        <= 1'b0;
                words_loaded <= '0;
                sum          <= '0;
                idle_cnt     <= '0;
            end else begin
                if (transfer) begin
                    sum      <= sum + bus.rx_data;
                    idle_cnt <= '0;
                    case (state)
                        LEN_HI:  len_hi       <= bus.rx_data;
                        LEN_LO:  length       <= len_rx;
                        DATA_HI: data_hi      <= bus.rx_data;
                        DATA_LO: words_loaded <= words_loaded + (ADDR_W + 1)'(1);
                        default: ;
                    endcase
                end else if (rx_state) begin
                    idle_cnt <= idle_cnt + 32'd1;
                end
                if (state == CSUM && state_n == RUN)     image_valid <= 1'b1;
                if (state != ERROR && state_n == ERROR)  error       <= 1'b1;
            end
        end
    end

    assign rom_we = transfer && (state == DATA_LO);

    rom_mem #(.ADDR_W(ADDR_W)) u_rom (
        .clk   (clk),
        .we    (rom_we),
        .waddr (words_loaded[ADDR_W-1:0]),
        .wdata ({data_hi, bus.rx_data}),
        .raddr (bus.pcaddr[ADDR_W-1:0]),
        .rdata (rom_rdata)
    );

    // Fetches beyond the ROM read as zero.
    assign bus.instruction  = ((bus.pcaddr >> ADDR_W) == '0) ? rom_rdata : '0;
    assign bus.rx_ready     = rx_ready;
    assign bus.busy         = busy;
    assign bus.cpu_reset    = cpu_reset;
    assign bus.image_valid  = image_valid;
    assign bus.error        = error;
    assign bus.words_loaded = words_loaded;

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: directed protocol cases plus randomized
// images, all compared each cycle against a byte-position model of the protocol.
module tb_rom_loader;
    import hack_pkg::*;

    localparam int AW    = 4;
    localparam int TO    = 8;
    localparam int DEPTH = 2 ** AW;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rom_loader_if #(.ADDR_W(AW)) bus ();
    rom_loader #(.ADDR_W(AW), .TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    // Model: protocol position within the stream rather than named states.
    bit          m_loading, m_valid, m_error;
    int          m_pos, m_n, m_words, m_idle;
    logic [7:0]  m_sum, m_hi, m_dhi;
    logic [15:0] m_rom [DEPTH];
    bit          m_known [DEPTH];
    logic [15:0] cur_pc = 16'd0;
    bit          rnd_pc = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_loading = 1'b0; m_valid = 1'b0; m_error = 1'b0;
        m_words = 0; m_idle = 0;
    endtask

    task automatic model_fail();
        m_loading = 1'b0; m_error = 1'b1;
    endtask

    task automatic model_step(input bit lr, input bit v, input logic [7:0] d);
        int idx;
        if (!m_loading) begin
            if (lr) begin
                m_loading = 1'b1; m_pos = 0; m_sum = 8'h00; m_idle = 0;
                m_valid = 1'b0; m_error = 1'b0; m_words = 0;
            end
        end else if (v) begin
            m_idle = 0;
            if (m_pos == 0) m_hi = d;
            else if (m_pos == 1) begin
                m_n = int'({m_hi, d});
                if (m_n > DEPTH) model_fail();
            end else if (m_pos < 2 * m_n + 2) begin
                if (m_pos % 2 == 0) m_dhi = d;
                else begin
                    idx = (m_pos - 2) / 2;
                    m_rom[idx]   = {m_dhi, d};
                    m_known[idx] = 1'b1;
                    m_words++;
                end
            end else begin
                if (d == m_sum) begin m_loading = 1'b0; m_valid = 1'b1; end
                else model_fail();
            end
            m_sum = m_sum + d;
            m_pos++;
        end else begin
            m_idle++;
            if (m_idle == TO) model_fail();
        end
    endtask

    // Drives one clock cycle of inputs, starting just after a rising edge.
    task automatic tick(input bit lr, input bit v, input logic [7:0] d);
        if (rnd_pc) cur_pc = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom_range(0, 20));
        bus.load_req = lr; bus.rx_valid = v; bus.rx_data = d; bus.pcaddr = cur_pc;
        @(posedge clk);
        model_step(lr, v, d);
        #1;
        bus.load_req = 1'b0; bus.rx_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        repeat (gap) tick(1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b1, b);
    endtask

    task automatic load(input logic [7:0] q[$], input int gap);
        tick(1'b1, 1'b0, 8'h00);
        foreach (q[i]) send(q[i], gap);
    endtask

    always @(negedge clk) begin
        if (cmp_en && !reset) begin
            check("rx_ready",     32'(bus.rx_ready),     32'(m_loading));
            check("busy",         32'(bus.busy),         32'(m_loading));
            check("cpu_reset",    32'(bus.cpu_reset),    32'(!(m_valid && !m_loading)));
            check("image_valid",  32'(bus.image_valid),  32'(m_valid));
            check("error",        32'(bus.error),        32'(m_error));
            check("words_loaded", 32'(bus.words_loaded), 32'(m_words));
            if (bus.pcaddr >= 16'(DEPTH))
                check("instr_oob", 32'(bus.instruction), 32'd0);
            else if (m_known[bus.pcaddr[AW-1:0]])
                check("instr", 32'(bus.instruction), 32'(m_rom[bus.pcaddr[AW-1:0]]));
        end
    end

    initial begin
        logic [7:0] q[$];
        logic [7:0] cs;
        int n, gap;
        foreach (m_known[i]) m_known[i] = 1'b0;
        bus.load_req = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.pcaddr = 16'h0000;
        reset = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("por_cpu_reset",   32'(bus.cpu_reset),   32'd1);
        check("por_image_valid", 32'(bus.image_valid), 32'd0);
        check("por_rx_ready",    32'(bus.rx_ready),    32'd0);
        reset = 1'b0;
        cmp_en = 1'b1;
        repeat (100) tick(1'b0, 1'b0, 8'h00);
        check("idle_cpu_reset",   32'(bus.cpu_reset),   32'd1);
        check("idle_image_valid", 32'(bus.image_valid), 32'd0);
        check("idle_rx_ready",    32'(bus.rx_ready),    32'd0);

        // Good image; 02+12+34+AB+CD wraps to C0.
        load('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0}, 0);
        check("good_image_valid", 32'(bus.image_valid),  32'd1);
        check("good_cpu_reset",   32'(bus.cpu_reset),    32'd0);
        check("good_words",       32'(bus.words_loaded), 32'd2);
        check("model_good_valid", 32'(m_valid),          32'd1);
        bus.pcaddr = 16'd0; #1;
        check("good_rom0", 32'(bus.instruction), 32'h1234);
        bus.pcaddr = 16'd1; cur_pc = 16'd1; #1;
        check("good_rom1", 32'(bus.instruction), 32'hABCD);

        load('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC1}, 1);
        check("badcs_error",     32'(bus.error),       32'd1);
        check("badcs_valid",     32'(bus.image_valid), 32'd0);
        check("badcs_cpu_reset", 32'(bus.cpu_reset),   32'd1);

        load('{8'h00, 8'h11}, 0);
        check("oversize_error", 32'(bus.error), 32'd1);
        check("oversize_busy",  32'(bus.busy),  32'd0);

        load('{8'h00, 8'h00, 8'h00}, 0);
        check("empty_valid", 32'(bus.image_valid),  32'd1);
        check("empty_words", 32'(bus.words_loaded), 32'd0);

        load('{8'h00, 8'h01, 8'h12}, 0);
        repeat (7) tick(1'b0, 1'b0, 8'h00);
        check("stall7_busy", 32'(bus.busy), 32'd1);
        tick(1'b0, 1'b0, 8'h00);
        check("stall8_error", 32'(bus.error), 32'd1);
        check("stall8_busy",  32'(bus.busy),  32'd0);

        load('{8'h00, 8'h01, 8'h56, 8'h78, 8'hCF}, 7);
        check("gap7_valid", 32'(bus.image_valid), 32'd1);

        // Reset lands asynchronously while waiting for DATA_HI.
        load('{8'h00, 8'h01}, 0);
        tick(1'b0, 1'b0, 8'h00);
        #2 reset = 1'b1;
        #1;
        check("midrst_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        check("midrst_busy",      32'(bus.busy),      32'd0);
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;

        load('{8'h00, 8'h01}, 0);
        tick(1'b1, 1'b0, 8'h00);
        send(8'h9A, 0); send(8'hBC, 0); send(8'h57, 0);
        check("ignore_req_valid", 32'(bus.image_valid),  32'd1);
        check("ignore_req_words", 32'(bus.words_loaded), 32'd1);

        bus.pcaddr = 16'h8000; cur_pc = 16'h8000; #1;
        check("pc_8000", 32'(bus.instruction), 32'd0);

        rnd_pc = 1'b1;
        for (int it = 0; it < 40; it++) begin
            n = ($urandom_range(0, 9) == 0) ? 17 : $urandom_range(0, DEPTH);
            q = {};
            q.push_back(8'(n >> 8));
            q.push_back(8'(n));
            for (int w = 0; w < 2 * n; w++) q.push_back(8'($urandom_range(0, 255)));
            cs = 8'h00;
            foreach (q[i]) cs = cs + q[i];
            if ($urandom_range(0, 3) == 0) cs = cs ^ 8'(1 << $urandom_range(0, 7));
            q.push_back(cs);
            tick(1'b1, 1'b0, 8'h00);
            foreach (q[i]) begin
                gap = ($urandom_range(0, 29) == 0) ? 9 : $urandom_range(0, 3);
                repeat (gap) tick($urandom_range(0, 15) == 0, 1'b0, 8'h00);
                tick(1'b0, 1'b1, q[i]);
            end
            repeat ($urandom_range(1, 4)) tick(1'b0, 1'b0, 8'h00);
        end
        rnd_pc = 1'b0;

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
